// File: rtl/hub75_panel_rx.sv
// HUB75 receive model: synchronises panel pins, rebuilds each 32-column shift,
// latches on STB, commits the row pair to a 32xWIDTHx3 frame store on OE falling.
module hub75_panel_rx #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter logic [15:0] FRAME_COUNT_INIT = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        led_clk_in,
  input  logic        stb_in,
  input  logic        oe_in,
  input  logic [3:0]  sel_abcd_in,
  input  logic        r0_in,
  input  logic        g0_in,
  input  logic        b0_in,
  input  logic        r1_in,
  input  logic        g1_in,
  input  logic        b1_in,
  input  logic [4:0]  rd_row,
  input  logic [4:0]  rd_col,
  output logic [2:0]  rd_rgb,
  output logic        row_strobe,
  output logic [3:0]  row_index,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        shift_err,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    ST_SHIFT   = 2'd0,
    ST_LATCHED = 2'd1,
    ST_SHOW    = 2'd2
  } state_t;

  localparam int unsigned NB = 13;
  // oe idles high so the chain resets to 1 and cannot fake a falling edge
  localparam logic [NB-1:0] SYNC_RST = 13'h1000;

  logic [NB-1:0]    r_sync [SYNC_STAGES];
  logic [2:0]       r_prev;
  logic [WIDTH-1:0] r_sr   [6];
  logic [WIDTH-1:0] r_lat  [6];
  logic [WIDTH-1:0] w_sr_next [6];
  logic [2:0]       r_frame [32][WIDTH];
  logic [5:0]       r_cnt;
  logic [5:0]       w_cnt_next;
  logic             r_shift_err;
  logic [2:0]       r_rd_rgb;
  logic             r_row_strobe;
  logic [3:0]       r_row_index;
  logic             r_frame_done;
  logic [15:0]      r_frame_count;
  state_t           r_state;
  state_t           w_state_next;

  logic [NB-1:0] w_pins;
  logic [NB-1:0] w_s;
  logic          w_lclk_rise;
  logic          w_stb_rise;
  logic          w_oe_fall;
  logic          w_oe_rise;
  logic [3:0]    w_sel;
  logic [5:0]    w_bits;

  assign w_pins = {oe_in, stb_in, led_clk_in, sel_abcd_in,
                   r0_in, g0_in, b0_in, r1_in, g1_in, b1_in};
  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_lclk_rise = w_s[10] & ~r_prev[0];
  assign w_stb_rise  = w_s[11] & ~r_prev[1];
  assign w_oe_fall   = ~w_s[12] & r_prev[2];
  assign w_oe_rise   = w_s[12] & ~r_prev[2];
  assign w_sel       = w_s[9:6];
  assign w_bits      = w_s[5:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RST;
      r_prev <= 3'b100;
    end else begin
      r_sync[0] <= w_pins;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_s[12:10];
    end
  end

  // Latch sees the post-shift value so a coincident STB includes the new bit
  always_comb begin
    for (int unsigned k = 0; k < 6; k++) begin
      w_sr_next[k] = r_sr[k];
      if (w_lclk_rise) w_sr_next[k] = {r_sr[k][WIDTH-2:0], w_bits[5-k]};
    end
    w_cnt_next = r_cnt;
    if (w_lclk_rise && r_cnt != 6'd63) w_cnt_next = r_cnt + 6'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < 6; k++) begin
        r_sr[k]  <= '0;
        r_lat[k] <= '0;
      end
      r_cnt       <= '0;
      r_shift_err <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < 6; k++) r_sr[k] <= w_sr_next[k];
      if (w_stb_rise) begin
        for (int unsigned k = 0; k < 6; k++) r_lat[k] <= w_sr_next[k];
        r_shift_err <= r_shift_err | (w_cnt_next != 6'(WIDTH));
        r_cnt       <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < 32; r++)
        for (int unsigned c = 0; c < WIDTH; c++) r_frame[r][c] <= '0;
      r_rd_rgb      <= '0;
      r_row_strobe  <= 1'b0;
      r_row_index   <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= FRAME_COUNT_INIT;
    end else begin
      r_rd_rgb     <= r_frame[rd_row][rd_col];
      r_row_strobe <= w_oe_fall;
      r_frame_done <= w_oe_fall && (w_sel == 4'd15);
      if (w_oe_fall) begin
        for (int unsigned c = 0; c < WIDTH; c++) begin
          r_frame[{1'b0, w_sel}][c] <= {r_lat[0][WIDTH-1-c], r_lat[1][WIDTH-1-c], r_lat[2][WIDTH-1-c]};
          r_frame[{1'b1, w_sel}][c] <= {r_lat[3][WIDTH-1-c], r_lat[4][WIDTH-1-c], r_lat[5][WIDTH-1-c]};
        end
        r_row_index <= w_sel;
        if (w_sel == 4'd15) r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_SHIFT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SHIFT:   if (w_stb_rise) w_state_next = ST_LATCHED;
      ST_LATCHED: if (!w_stb_rise && w_oe_fall) w_state_next = ST_SHOW;
      ST_SHOW: begin
        if (w_stb_rise)     w_state_next = ST_LATCHED;
        else if (w_oe_rise) w_state_next = ST_SHIFT;
      end
      default:    w_state_next = ST_SHIFT;
    endcase
  end

  assign rd_rgb      = r_rd_rgb;
  assign row_strobe  = r_row_strobe;
  assign row_index   = r_row_index;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign shift_err   = r_shift_err;
  assign state_out   = r_state;

endmodule

// File: tb/tb_hub75_panel_rx.sv
// Scoreboard bench for hub75_panel_rx: pin-level row stimulus, frame model in arrays,
// commit events and read data checked by a monitor as the DUT presents them.
module tb_hub75_panel_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        led_clk_in = 1'b0, stb_in = 1'b0, oe_in = 1'b1;
  logic [3:0]  sel_abcd_in = '0;
  logic        r0_in = 1'b0, g0_in = 1'b0, b0_in = 1'b0;
  logic        r1_in = 1'b0, g1_in = 1'b0, b1_in = 1'b0;
  logic [4:0]  rd_row = '0, rd_col = '0;
  logic [2:0]  rd_rgb;
  logic        row_strobe, frame_done, shift_err;
  logic [3:0]  row_index;
  logic [15:0] frame_count;
  logic [1:0]  state_out;

  logic [2:0]  w_rd_rgb;
  logic        w_row_strobe, w_frame_done, w_shift_err;
  logic [3:0]  w_row_index;
  logic [15:0] w_frame_count;
  logic [1:0]  w_state_out;

  always #5 clk = ~clk;

  hub75_panel_rx dut (
    .clk(clk), .reset(reset), .led_clk_in(led_clk_in), .stb_in(stb_in), .oe_in(oe_in),
    .sel_abcd_in(sel_abcd_in), .r0_in(r0_in), .g0_in(g0_in), .b0_in(b0_in),
    .r1_in(r1_in), .g1_in(g1_in), .b1_in(b1_in), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rgb(rd_rgb), .row_strobe(row_strobe), .row_index(row_index),
    .frame_done(frame_done), .frame_count(frame_count), .shift_err(shift_err),
    .state_out(state_out));

  // Second instance preloaded to 0xFFFF so the counter wrap is reachable quickly
  hub75_panel_rx #(.FRAME_COUNT_INIT(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(reset), .led_clk_in(led_clk_in), .stb_in(stb_in), .oe_in(oe_in),
    .sel_abcd_in(sel_abcd_in), .r0_in(r0_in), .g0_in(g0_in), .b0_in(b0_in),
    .r1_in(r1_in), .g1_in(g1_in), .b1_in(b1_in), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rgb(w_rd_rgb), .row_strobe(w_row_strobe), .row_index(w_row_index),
    .frame_done(w_frame_done), .frame_count(w_frame_count), .shift_err(w_shift_err),
    .state_out(w_state_out));

  typedef struct packed {
    logic [3:0]  idx;
    logic        done;
    logic [15:0] cnt;
  } ev_t;

  ev_t         evq[$];
  logic [2:0]  rdq[$];
  logic [2:0]  m_frame [32][32];
  logic [15:0] m_count;
  logic [2:0]  row_up [32];
  logic [2:0]  row_lo [32];
  logic        rd_req = 1'b0;
  logic        rd_pend = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rdq.size() == 0) check("rd_underflow", 32'd1, 32'd0);
      else check("rd_rgb", {29'd0, rd_rgb}, {29'd0, rdq.pop_front()});
    end
    if (row_strobe) begin
      if (evq.size() == 0) check("unexpected_row_strobe", 32'd1, 32'd0);
      else begin
        ev_t e;
        e = evq.pop_front();
        check("row_index", {28'd0, row_index}, {28'd0, e.idx});
        check("frame_done", {31'd0, frame_done}, {31'd0, e.done});
        check("frame_count", {16'd0, frame_count}, {16'd0, e.cnt});
        check("wrap_frame_count", {16'd0, w_frame_count}, {16'd0, 16'(e.cnt - 16'd1)});
      end
    end
    if (frame_done && !row_strobe) check("frame_done_alone", 32'd1, 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) m_frame[r][c] = '0;
    m_count = '0;
  endtask

  task automatic set_bits(input logic [2:0] up, input logic [2:0] lo);
    {r0_in, g0_in, b0_in} = up;
    {r1_in, g1_in, b1_in} = lo;
  endtask

  task automatic shift_bit(input logic [2:0] up, input logic [2:0] lo, input logic with_stb);
    set_bits(up, lo);
    led_clk_in = 1'b0;
    tick(2);
    led_clk_in = 1'b1;
    stb_in = with_stb;
    tick(2);
    led_clk_in = 1'b0;
    stb_in = 1'b0;
  endtask

  task automatic send_row(input logic [3:0] sel, input int nshift, input logic combined,
                          input logic commit);
    sel_abcd_in = sel;
    for (int i = 0; i < nshift; i++)
      shift_bit(row_up[i], row_lo[i], combined && (i == nshift - 1));
    tick(2);
    if (!combined) begin
      stb_in = 1'b1;
      tick(2);
      stb_in = 1'b0;
    end
    tick(5);
    check("state_latched", {30'd0, state_out}, 32'd1);
    if (commit) begin
      for (int c = 0; c < 32; c++) begin
        m_frame[sel][c]      = row_up[c];
        m_frame[sel + 16][c] = row_lo[c];
      end
      if (sel == 4'd15) m_count = m_count + 16'd1;
      evq.push_back('{idx: sel, done: (sel == 4'd15), cnt: m_count});
      oe_in = 1'b0;
      tick(6);
      check("state_show", {30'd0, state_out}, 32'd2);
      oe_in = 1'b1;
      tick(6);
      check("state_shift", {30'd0, state_out}, 32'd0);
    end
  endtask

  task automatic read_all();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        rd_row = 5'(r);
        rd_col = 5'(c);
        rd_req = 1'b1;
        rdq.push_back(m_frame[r][c]);
        tick(1);
      end
    rd_req = 1'b0;
    tick(3);
  endtask

  task automatic fill_random();
    for (int c = 0; c < 32; c++) begin
      row_up[c] = 3'($urandom_range(7));
      row_lo[c] = 3'($urandom_range(7));
    end
  endtask

  initial begin
    do_reset();
    check("rst_rd_rgb", {29'd0, rd_rgb}, 32'd0);
    check("rst_row_strobe", {31'd0, row_strobe}, 32'd0);
    check("rst_row_index", {28'd0, row_index}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_shift_err", {31'd0, shift_err}, 32'd0);
    check("rst_state", {30'd0, state_out}, 32'd0);
    check("rst_wrap_count", {16'd0, w_frame_count}, 32'h0000FFFF);

    // single row: R0 on column 0, G1 on column 31
    for (int c = 0; c < 32; c++) begin
      row_up[c] = (c == 0)  ? 3'b100 : 3'b000;
      row_lo[c] = (c == 31) ? 3'b010 : 3'b000;
    end
    send_row(4'd3, 32, 1'b0, 1'b1);
    check("row3_shift_err", {31'd0, shift_err}, 32'd0);
    read_all();

    // full frame with pattern (row+col)%8
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 32; c++) begin
        row_up[c] = 3'((s + c) % 8);
        row_lo[c] = 3'((s + 16 + c) % 8);
      end
      send_row(4'(s), 32, 1'b0, 1'b1);
    end
    check("frame_count_after_frame", {16'd0, frame_count}, 32'd1);
    check("wrap_count_after_frame", {16'd0, w_frame_count}, 32'd0);
    read_all();

    // random rows, one forced to row pair 15
    for (int n = 0; n < 4; n++) begin
      fill_random();
      send_row((n == 3) ? 4'd15 : 4'($urandom_range(15)), 32, 1'b0, 1'b1);
    end
    read_all();

    // short shift sets the sticky error, later good rows leave it set
    fill_random();
    send_row(4'd0, 31, 1'b0, 1'b0);
    check("short_shift_err", {31'd0, shift_err}, 32'd1);
    fill_random();
    send_row(4'd7, 32, 1'b0, 1'b1);
    check("sticky_shift_err", {31'd0, shift_err}, 32'd1);

    // STB coincident with the 32nd shift clock
    do_reset();
    check("rst2_shift_err", {31'd0, shift_err}, 32'd0);
    fill_random();
    send_row(4'd9, 32, 1'b1, 1'b1);
    check("coincident_shift_err", {31'd0, shift_err}, 32'd0);
    read_all();

    // reset in the middle of a row discards the partial shift
    for (int i = 0; i < 10; i++) shift_bit(3'b111, 3'b111, 1'b0);
    do_reset();
    fill_random();
    send_row(4'd5, 32, 1'b0, 1'b1);
    check("post_reset_shift_err", {31'd0, shift_err}, 32'd0);
    check("post_reset_frame_count", {16'd0, frame_count}, 32'd0);
    read_all();

    tick(4);
    check("events_drained", evq.size(), 32'd0);
    check("reads_drained", rdq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hub75_panel_rx.md
# hub75_panel_rx

Receive-side model of the HUB75 panel interface driven by the team's LED matrix driver. It oversamples LED_CLK/STB/OE/ABCD and the six colour bits, reconstructs each 32-column shift, latches it on STB, commits it into a 32x32x3 frame store when OE asserts, and exposes the frame through a registered read port. It is used in loop-back bring-up and self-check builds, and in system simulation as the panel stand-in.

## Interface
- WIDTH, 32: columns per shift (bits per colour line per row).
- SYNC_STAGES, 2: synchroniser flops on every panel input (≥2).
- clk  in  1  receiver clock; frequency ≥ the driver clock.
- reset  in  1  asynchronous, active-high.
- led_clk_in, stb_in, oe_in  in  1 each  panel shift clock, latch strobe, output enable (active-low).
- sel_abcd_in  in  4  row-pair select.
- r0_in, g0_in, b0_in, r1_in, g1_in, b1_in  in  1 each  upper-half (0) and lower-half (1) colour data.
- rd_row  in  5  frame read row (0-15 upper, 16-31 lower); rd_col  in  5  read column.
- rd_rgb  out  3  {R,G,B} at rd_row/rd_col, registered.
- row_strobe  out  1  one-cycle pulse when a row pair is committed; row_index  out  4  sel of that commit.
- frame_done  out  1  one-cycle pulse coincident with row_strobe when row_index==15.
- frame_count  out  16  committed frames, wraps at 0xFFFF->0.
- shift_err  out  1  sticky: a latch occurred with shift count ≠ WIDTH.
- state_out  out  2  current FSM state (debug).

## Operation
- All panel inputs pass through SYNC_STAGES flops, then one edge-detect register for led_clk, stb, oe. Data bits and ABCD are delayed identically to stay aligned with led_clk.
- Synced led_clk rising: each of six shift registers does sr <= {sr[WIDTH-2:0], bit}; shift_cnt (6-bit) increments, saturating at 63. First bit shifted is column 0, so after WIDTH shifts column c = sr[WIDTH-1-c].
- Synced stb rising: six latch registers <= sr; shift_err <= 1 if shift_cnt ≠ WIDTH; shift_cnt <= 0. Shift and STB rising in the same cycle: shift applied first, latch and count include the new bit.
- Synced oe falling: latch upper colours written to frame row sel, lower to row sel+16, all WIDTH columns in one cycle; row_strobe=1, row_index=sel; if sel==15, frame_done=1 and frame_count increments.
- FSM (state_out encoding): SHIFT(0) accumulating -> LATCHED(1) on stb rising -> SHOW(2) on oe falling -> SHIFT on oe rising. OE falling in SHIFT still commits (stale latch), no error. STB rising in LATCHED re-latches and stays. STB rising in SHOW re-latches and moves to LATCHED. led_clk shifting is accepted in every state.
- Read port: rd_rgb <= frame[rd_row][rd_col] every cycle; a commit to the addressed row in the same cycle returns the old value.
- Reset (async): all sync/edge flops 0 except oe chain 1 (no false falling edge), shift/latch regs 0, frame store 0, shift_cnt 0, state SHIFT; rd_rgb 0, row_strobe 0, row_index 0, frame_done 0, frame_count 0, shift_err 0. Reset mid-row discards partial shift; the next commit uses fresh data only.

## Timing
- Input requirements at pins: led_clk high ≥1 and low ≥1 clk cycle; data stable in the cycle led_clk is sampled high; STB and OE pulses ≥1 cycle.
- Pin edge in cycle t -> internal action at clock edge t+SYNC_STAGES+1 (3 cycles default).
- row_strobe/frame_done asserted in that action cycle; new data visible on rd_rgb one cycle later (read address applied in the action cycle).
- Throughput: one bit per led_clk period; back-to-back rows need no gap beyond the driver's own.

## Test plan
- Reset then drive one row: 32 shifts with R0=1 only on col 0, G1=1 only on col 31, STB, OE low at sel=3 -> row_strobe with row_index=3; rd(3,0)=3'b100, rd(19,31)=3'b010, all others 0; shift_err=0.
- Full frame of 16 rows, pattern rgb=(row+col)%8 -> frame_done once after sel=15, frame_count=1; every rd address matches the pattern.
- 31 shifts then STB -> shift_err=1, stays 1 across later correct rows until reset.
- STB rising in the same synced cycle as the 32nd led_clk rising -> latch contains all 32 bits, shift_err=0.
- Assert reset after 10 shifts of a row, release, send a full row -> committed row holds only post-reset data; frame store otherwise 0.
- 65536 frames (or preloaded count 0xFFFF) -> frame_count wraps to 0 on next frame_done.
